// File: rtl/module_keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits one single-cycle 'tecla' strobe plus a 4-bit key code per physical press.
// Optional build macro KEYPAD_DIGIT_FILTER_EN: only keys 0-9 produce a strobe.
module module_keypad_scan #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       tecla,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  // Press needs DEBOUNCE_CYCLES+1 equal samples so tecla lands DEBOUNCE_CYCLES+1 after entry.
  localparam logic [CntW-1:0] PressLast = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] RelLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      ColFirst  = 4'b1110;

  typedef enum logic [2:0] {
    StScan     = 3'd0,
    StDebounce = 3'd1,
    StStrobe   = 3'd2,
    StWaitRel  = 3'd3,
    StRelDb    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      col_q, col_d;
  logic [3:0]      pat_q, pat_d;
  logic            tecla_q, tecla_d;
  logic [3:0]      code_q, code_d;
  logic            down_q, down_d;
  logic [3:0]      row_meta_q, rows_s;
  logic [3:0]      col_rot;
  logic [3:0]      code_new;

  // Map latched row pattern and active column to a key code; lowest low row wins.
  function automatic logic [3:0] key_lookup(input logic [3:0] pat, input logic [3:0] col);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    r = 2'd3;
    c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) r = 2'(i);
    end
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) c = 2'(i);
    end
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign col_rot  = {col_q[2:0], col_q[3]};
  assign code_new = key_lookup(pat_q, col_q);

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      rows_s     <= 4'hF;
    end else begin
      row_meta_q <= row_n;
      rows_s     <= row_meta_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StScan;
      cnt_q   <= '0;
      col_q   <= ColFirst;
      pat_q   <= 4'hF;
      tecla_q <= 1'b0;
      code_q  <= 4'h0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
      tecla_q <= tecla_d;
      code_q  <= code_d;
      down_q  <= down_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    col_d   = col_q;
    pat_d   = pat_q;
    tecla_d = 1'b0;
    code_d  = code_q;
    down_d  = down_q;
    unique case (state_q)
      StScan: begin
        if (cnt_q == ScanLast) begin
          cnt_d = '0;
          if (rows_s == 4'hF) begin
            col_d = col_rot;
          end else begin
            pat_d   = rows_s;
            state_d = StDebounce;
          end
        end
      end
      StDebounce: begin
        if (rows_s != pat_q) begin
          state_d = StScan;
          cnt_d   = '0;
          col_d   = col_rot;
        end else if (cnt_q == PressLast) begin
          cnt_d = '0;
`ifdef KEYPAD_DIGIT_FILTER_EN
          if (code_new <= 4'h9) begin
            state_d = StStrobe;
            tecla_d = 1'b1;
            code_d  = code_new;
            down_d  = 1'b1;
          end else begin
            // Letter keys still wait for release so they cannot be re-detected.
            state_d = StWaitRel;
          end
`else
          state_d = StStrobe;
          tecla_d = 1'b1;
          code_d  = code_new;
          down_d  = 1'b1;
`endif
        end
      end
      StStrobe: begin
        state_d = StWaitRel;
        cnt_d   = '0;
      end
      StWaitRel: begin
        cnt_d = '0;
        if (rows_s == 4'hF) state_d = StRelDb;
      end
      StRelDb: begin
        if (rows_s != 4'hF) begin
          state_d = StWaitRel;
          cnt_d   = '0;
        end else if (cnt_q == RelLast) begin
          state_d = StScan;
          cnt_d   = '0;
          down_d  = 1'b0;
          col_d   = col_rot;
        end
      end
      default: begin
        state_d = StScan;
        cnt_d   = '0;
        col_d   = ColFirst;
        down_d  = 1'b0;
      end
    endcase
  end

  assign col_n    = col_q;
  assign tecla    = tecla_q;
  assign key_code = code_q;
  assign key_down = down_q;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Directed bench for module_keypad_scan: keypad model drives rows from the scanned columns,
// expected key codes are queued per press and popped on each tecla strobe.
module tb_module_keypad_scan;

  logic       clk;
  logic       rst;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       tecla;
  logic [3:0] key_code;
  logic       key_down;

  int         n_checks = 0;
  int         n_errors = 0;
  int         strobe_cnt = 0;
  logic [3:0] sb[$];
  logic       prev_tecla = 1'b0;

  logic key_on = 1'b0;
  int   key_r  = 0;
  int   key_c  = 0;

  module_keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_n   (row_n),
    .col_n   (col_n),
    .tecla   (tecla),
    .key_code(key_code),
    .key_down(key_down)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad model: the held key pulls its row low only while its column is driven.
  always_comb begin
    row_n = 4'hF;
    if (key_on && (col_n[key_c] == 1'b0)) row_n[key_r] = 1'b0;
  end

  // Strobe monitor: pop the expected code for every tecla pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (tecla) begin
        logic [3:0] exp_code;
        strobe_cnt++;
        n_checks++;
        assert (sb.size() != 0) else begin
          n_errors++;
          $error("FAIL strobe_unexpected: got code %h, expected no strobe", key_code);
        end
        if (sb.size() != 0) begin
          exp_code = sb.pop_front();
          n_checks++;
          assert (key_code === exp_code) else begin
            n_errors++;
            $error("FAIL strobe_code: got %h expected %h", key_code, exp_code);
          end
        end
        n_checks++;
        assert (prev_tecla === 1'b0) else begin
          n_errors++;
          $error("FAIL tecla_back_to_back: got 1 expected 0 on previous cycle");
        end
      end
      prev_tecla = tecla;
    end else begin
      prev_tecla = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_down(input logic val, input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      if (key_down === val) break;
      tick(1);
    end
    n_checks++;
    assert (key_down === val) else begin
      n_errors++;
      $error("FAIL %s: key_down got %b expected %b within %0d cycles", tag, key_down, val,
             budget);
    end
  endtask

  task automatic press_release(input int r, input int c, input logic [3:0] code,
                               input string tag);
    int s0;
    s0 = strobe_cnt;
    sb.push_back(code);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
    wait_down(1'b1, 200, {tag, "_press"});
    tick(20);
    check4({tag, "_strobes"}, 4'(strobe_cnt - s0), 4'd1);
    check4({tag, "_held_code"}, key_code, code);
    key_on = 1'b0;
    wait_down(1'b0, 200, {tag, "_release"});
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check4("reset_col", col_n, 4'b1110);
    check4("reset_tecla", {3'b0, tecla}, 4'd0);
    check4("reset_code", key_code, 4'h0);
    check4("reset_down", {3'b0, key_down}, 4'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Column rotation with no key pressed.
    tick(3);
    check4("scan_col0", col_n, 4'b1110);
    tick(1);
    check4("scan_col1", col_n, 4'b1101);
    tick(4);
    check4("scan_col2", col_n, 4'b1011);
    tick(4);
    check4("scan_col3", col_n, 4'b0111);
    tick(4);
    check4("scan_wrap", col_n, 4'b1110);

    // Hold '5' for 60 cycles; release must take at least the debounce window.
    s0 = strobe_cnt;
    sb.push_back(4'h5);
    key_r = 1; key_c = 1; key_on = 1'b1;
    tick(60);
    check4("key5_strobes", 4'(strobe_cnt - s0), 4'd1);
    check4("key5_down", {3'b0, key_down}, 4'd1);
    key_on = 1'b0;
    tick(5);
    check4("key5_down_early_release", {3'b0, key_down}, 4'd1);
    wait_down(1'b0, 40, "key5_release");

    // Bouncing '1' never strobes until it settles.
    tick(10);
    s0 = strobe_cnt;
    sb.push_back(4'h1);
    key_r = 0; key_c = 0;
    for (int i = 0; i < 8; i++) begin
      key_on = ~key_on;
      tick(3);
    end
    check4("bounce_no_strobe", 4'(strobe_cnt - s0), 4'd0);
    check4("bounce_no_down", {3'b0, key_down}, 4'd0);
    key_on = 1'b1;
    wait_down(1'b1, 200, "bounce_settle");
    tick(5);
    check4("bounce_strobes", 4'(strobe_cnt - s0), 4'd1);
    key_on = 1'b0;
    wait_down(1'b0, 200, "bounce_release");

    // Digit sequence 1, 2, 3 then letter 'A'.
    press_release(0, 0, 4'h1, "seq1");
    press_release(0, 1, 4'h2, "seq2");
    press_release(0, 2, 4'h3, "seq3");
    press_release(0, 3, 4'hA, "keyA");

    // Reset while a key is held in WAIT_REL, then re-detection after reset.
    sb.push_back(4'h7);
    key_r = 2; key_c = 0; key_on = 1'b1;
    wait_down(1'b1, 200, "key7_press");
    tick(3);
    #2 rst = 1'b0;
    #1;
    check4("midreset_col", col_n, 4'b1110);
    check4("midreset_tecla", {3'b0, tecla}, 4'd0);
    check4("midreset_code", key_code, 4'h0);
    check4("midreset_down", {3'b0, key_down}, 4'd0);
    #4 rst = 1'b1;
    s0 = strobe_cnt;
    sb.push_back(4'h7);
    wait_down(1'b1, 200, "key7_redetect");
    tick(5);
    check4("key7_redetect_strobes", 4'(strobe_cnt - s0), 4'd1);
    check4("key7_redetect_code", key_code, 4'h7);
    key_on = 1'b0;
    wait_down(1'b0, 200, "key7_release");
    tick(40);

    check4("scoreboard_empty", 4'(sb.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
